// File: rtl/rf_write_arbiter_pkg.sv
// rf_write_arbiter shared constants and FSM state type.
// Build option: RF_ARB_FIXED_PRIO_EN selects fixed priority.
package rf_pkg;

  localparam int RF_ADDR_W   = 5;
  localparam int RF_DATA_W   = 32;
  localparam int RF_NUM_REGS = 32;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } rf_arb_state_t;

endpackage

// File: rtl/rf_write_arbiter_if.sv
// Writeback requester bundle: valid/ready per requester,
// packed target index and data.
interface rf_write_arbiter_if #(
  parameter int N_REQ  = 3,
  parameter int ADDR_W = rf_pkg::RF_ADDR_W,
  parameter int DATA_W = rf_pkg::RF_DATA_W
);

  logic [N_REQ-1:0]        req_valid;
  logic [N_REQ*ADDR_W-1:0] req_addr;
  logic [N_REQ*DATA_W-1:0] req_data;
  logic [N_REQ-1:0]        req_ready;

  modport master (
    output req_valid,
    output req_addr,
    output req_data,
    input  req_ready
  );

  modport slave (
    input  req_valid,
    input  req_addr,
    input  req_data,
    output req_ready
  );

endinterface

// File: rtl/rf_write_arbiter_rr_arbiter.sv
// Round-robin one-hot grant: first valid at or after ptr,
// searching upward with wrap-around.
module rr_arbiter #(
  parameter int N_REQ = 3,
  parameter int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] valid,
  input  logic [PTR_W-1:0] ptr,
  output logic [N_REQ-1:0] grant,
  output logic [PTR_W-1:0] gidx,
  output logic             found
);

  // Two passes: upper slice [ptr..N-1] first, then wrap to [0..ptr-1].
  always_comb begin
    grant = '0;
    gidx  = '0;
    found = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (!found && valid[i] && i >= int'(ptr)) begin
        grant[i] = 1'b1;
        gidx     = PTR_W'(i);
        found    = 1'b1;
      end
    end
    for (int i = 0; i < N_REQ; i++) begin
      if (!found && valid[i] && i < int'(ptr)) begin
        grant[i] = 1'b1;
        gidx     = PTR_W'(i);
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rf_write_arbiter.sv
// Register-file write-port arbiter with post-reset clear.
// Build option: RF_ARB_FIXED_PRIO_EN (fixed priority, no ptr).
module rf_write_arbiter
  import rf_pkg::*;
#(
  parameter int N_REQ  = 3,
  parameter int DATA_W = RF_DATA_W,
  parameter int ADDR_W = RF_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  rf_write_arbiter_if.slave req,
  output logic              rf_wen,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic              init_done
);

  localparam int NUM_REGS = 2 ** ADDR_W;
  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  rf_arb_state_t state, state_nxt;

  logic [ADDR_W-1:0] clr_cnt;
  logic              clr_last;
  logic [N_REQ-1:0]  grant;
  logic              found;
  logic              hs;
  logic [ADDR_W-1:0] gaddr;
  logic [DATA_W-1:0] gdata;
  logic              wen_nxt;
  logic [ADDR_W-1:0] addr_nxt;
  logic [DATA_W-1:0] data_nxt;

  assign clr_last = (clr_cnt == ADDR_W'(NUM_REGS - 1));

`ifdef RF_ARB_FIXED_PRIO_EN
  always_comb begin
    grant = '0;
    found = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (!found && req.req_valid[i]) begin
        grant[i] = 1'b1;
        found    = 1'b1;
      end
    end
  end
`else
  logic [PTR_W-1:0] ptr;
  logic [PTR_W-1:0] gidx;

  rr_arbiter #(
    .N_REQ (N_REQ),
    .PTR_W (PTR_W)
  ) u_arb (
    .valid (req.req_valid),
    .ptr   (ptr),
    .grant (grant),
    .gidx  (gidx),
    .found (found)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr <= '0;
    end else if (hs) begin
      ptr <= (gidx == PTR_W'(N_REQ - 1)) ? '0
                                         : gidx + PTR_W'(1);
    end
  end
`endif

  always_comb begin
    gaddr = '0;
    gdata = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant[i]) begin
        gaddr = gaddr | req.req_addr[i*ADDR_W +: ADDR_W];
        gdata = gdata | req.req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= INIT;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      INIT:    if (clr_last) state_nxt = RUN;
      RUN:     state_nxt = RUN;
      default: state_nxt = INIT;
    endcase
  end

  // Writes to $zero handshake but never reach the bank.
  always_comb begin
    init_done     = 1'b0;
    req.req_ready = '0;
    hs            = 1'b0;
    wen_nxt       = 1'b0;
    addr_nxt      = rf_waddr;
    data_nxt      = rf_wdata;
    unique case (state)
      INIT: begin
        wen_nxt  = 1'b1;
        addr_nxt = clr_cnt;
        data_nxt = '0;
      end
      RUN: begin
        init_done     = ~reset;
        req.req_ready = reset ? '0 : grant;
        hs            = found & ~reset;
        if (hs && gaddr != '0) begin
          wen_nxt  = 1'b1;
          addr_nxt = gaddr;
          data_nxt = gdata;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      clr_cnt  <= '0;
      rf_wen   <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
    end else begin
      rf_wen   <= wen_nxt;
      rf_waddr <= addr_nxt;
      rf_wdata <= data_nxt;
      if (state == INIT) clr_cnt <= clr_cnt + ADDR_W'(1);
    end
  end

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed + random bench for rf_write_arbiter with a
// write scoreboard and grant reference model.
module tb_rf_write_arbiter;

  typedef struct packed {
    logic        wen;
    logic [4:0]  addr;
    logic [31:0] data;
  } wr_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        rf_wen;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        init_done;

  rf_write_arbiter_if #(
    .N_REQ(3), .ADDR_W(5), .DATA_W(32)
  ) bus ();

  rf_write_arbiter #(
    .N_REQ(3), .DATA_W(32), .ADDR_W(5)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (bus),
    .rf_wen    (rf_wen),
    .rf_waddr  (rf_waddr),
    .rf_wdata  (rf_wdata),
    .init_done (init_done)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int fails  = 0;
  int total  = 0;

  wr_t         sb[$];
  logic        m_run;
  int          m_ptr;
  int          m_clr;
  logic [4:0]  m_addr;
  logic [31:0] m_data;
  logic [2:0]  obs_ready;
  int          last_g;
  int          exp_g;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int pick(logic [2:0] v, int p);
    for (int i = 0; i < 3; i++) begin
      int j;
      j = (p + i) % 3;
      if (v[j]) return j;
    end
    return -1;
  endfunction

  task automatic set_req(input int i,
                         input logic [4:0] a,
                         input logic [31:0] d);
    bus.req_addr[i*5 +: 5]   = a;
    bus.req_data[i*32 +: 32] = d;
  endtask

  task automatic tick;
    wr_t         e;
    logic [2:0]  er;
    logic [4:0]  a;
    logic [31:0] d;
    int          g;
    @(negedge clk);
    chk("sb_depth", 64'(sb.size()), 64'd1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("rf_wen", rf_wen, e.wen);
      chk("rf_waddr", rf_waddr, e.addr);
      chk("rf_wdata", rf_wdata, e.data);
    end
    chk("init_done", init_done, m_run && !reset);
    er = '0;
    g  = -1;
    if (!reset && m_run) begin
`ifdef RF_ARB_FIXED_PRIO_EN
      g = pick(bus.req_valid, 0);
`else
      g = pick(bus.req_valid, m_ptr);
`endif
      if (g >= 0) er[g] = 1'b1;
    end
    obs_ready = bus.req_ready;
    last_g    = g;
    chk("req_ready", bus.req_ready, er);
    if (reset) begin
      m_run  = 1'b0;
      m_clr  = 0;
      m_ptr  = 0;
      m_addr = '0;
      m_data = '0;
      sb.push_back('{1'b0, 5'd0, 32'd0});
    end else if (!m_run) begin
      m_addr = m_clr[4:0];
      m_data = '0;
      sb.push_back('{1'b1, m_addr, 32'd0});
      if (m_clr == 31) m_run = 1'b1;
      m_clr++;
    end else if (g >= 0) begin
      m_ptr = (g + 1) % 3;
      a = bus.req_addr[g*5 +: 5];
      d = bus.req_data[g*32 +: 32];
      if (a != 5'd0) begin
        m_addr = a;
        m_data = d;
        sb.push_back('{1'b1, a, d});
      end else begin
        sb.push_back('{1'b0, m_addr, m_data});
      end
    end else begin
      sb.push_back('{1'b0, m_addr, m_data});
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset         = 1'b1;
    bus.req_valid = '0;
    bus.req_addr  = '0;
    bus.req_data  = '0;
    m_run  = 1'b0;
    m_ptr  = 0;
    m_clr  = 0;
    m_addr = '0;
    m_data = '0;
    last_g = -1;

    @(posedge clk);
    #1;
    sb.push_back('{1'b0, 5'd0, 32'd0});
    tick();
    tick();
    reset = 1'b0;

    repeat (33) tick();
    chk("done_after_clear", init_done, 1'b1);

    set_req(1, 5'd7, 32'hDEADBEEF);
    bus.req_valid = 3'b010;
    tick();
    chk("grant_r1", obs_ready, 3'b010);
    chk("wr7_wen", rf_wen, 1'b1);
    chk("wr7_addr", rf_waddr, 5'd7);
    chk("wr7_data", rf_wdata, 32'hDEADBEEF);
    bus.req_valid = '0;
    tick();

    set_req(2, 5'd3, 32'hAAAA5555);
    bus.req_valid = 3'b100;
    tick();
    bus.req_valid = '0;
    tick();

    for (int i = 0; i < 3; i++)
      set_req(i, 5'(10 + i), 32'h100 + 32'(i));
    bus.req_valid = 3'b111;
    for (int k = 0; k < 6; k++) begin
      tick();
`ifdef RF_ARB_FIXED_PRIO_EN
      exp_g = 0;
`else
      exp_g = k % 3;
`endif
      chk("rr_seq", last_g, exp_g);
      chk("rr_wen", rf_wen, 1'b1);
    end
    bus.req_valid = '0;
    tick();

    set_req(0, 5'd0, 32'h12345678);
    bus.req_valid = 3'b001;
    tick();
    chk("zero_grant", obs_ready, 3'b001);
    chk("zero_no_wen", rf_wen, 1'b0);
    bus.req_valid = '0;

    set_req(0, 5'd20, 32'hC0DE0000);
    set_req(1, 5'd22, 32'hC0DE0001);
    set_req(2, 5'd21, 32'hC0DE0002);
    bus.req_valid = 3'b101;
    tick();
`ifdef RF_ARB_FIXED_PRIO_EN
    exp_g = 0;
`else
    exp_g = 2;
`endif
    chk("p1_first", last_g, exp_g);
    tick();
    chk("p1_second", last_g, 0);
    bus.req_valid = 3'b111;
    tick();
`ifdef RF_ARB_FIXED_PRIO_EN
    exp_g = 0;
`else
    exp_g = 1;
`endif
    chk("p1_ptr_end", last_g, exp_g);

    set_req(0, 5'd5, 32'h0000AAAA);
    set_req(1, 5'd5, 32'h0000BBBB);
    bus.req_valid = 3'b011;
    tick();
    tick();
    chk("same_addr_last", rf_waddr, 5'd5);

    repeat (40) begin
      bus.req_valid = 3'($urandom_range(0, 7));
      bus.req_addr  = 15'($urandom);
      bus.req_data  = {$urandom, $urandom, $urandom};
      tick();
    end

    set_req(2, 5'd9, 32'h99999999);
    bus.req_valid = 3'b100;
    reset = 1'b1;
    tick();
    chk("rst_ready", obs_ready, 3'b000);
    chk("rst_done", init_done, 1'b0);
    reset = 1'b0;
    bus.req_valid = 3'b111;
    tick();
    chk("restart_wen", rf_wen, 1'b1);
    chk("restart_addr", rf_waddr, 5'd0);
    repeat (9) tick();

    reset = 1'b1;
    tick();
    reset = 1'b0;
    repeat (34) tick();
    bus.req_valid = '0;
    tick();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
